// File: rtl/mem_port_arbiter.sv
// Arbitrates one fixed-latency memory port between instruction fetch (I) and load/store (D).
// Data accesses win contention; a saturating starvation counter periodically forces an I grant.
//
// state  | meaning
// S_IDLE | no access in flight, requests sampled
// S_ISSUE| memory command cycle (mem_en high)
// S_WAIT | counting down the memory read latency
// S_DONE | owner's done pulse is visible
module mem_port_arbiter #(
  parameter int XLEN       = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_req,
  input  logic [XLEN-1:0] i_addr,
  output logic [XLEN-1:0] i_rdata,
  output logic            i_done,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  output logic [XLEN-1:0] d_rdata,
  output logic            d_done,
  output logic            mem_en,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            mem_sel,
  output logic            busy
);

  localparam int LCW = $clog2(MEM_LAT + 1);
  localparam int SCW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [LCW-1:0] LAT_LOAD   = LCW'(MEM_LAT);
  localparam logic [SCW-1:0] STARVE_TOP = SCW'(STARVE_MAX);
  localparam bit             STARVE_EN  = (STARVE_MAX != 0);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [LCW-1:0]   lat_q;
  logic [SCW-1:0]   starve_q;
  logic             acc_we_q;
  logic             start;
  logic             grant_d;
  logic             capture;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    grant_d = 1'b0;
    capture = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_req || d_req) begin
          state_d = S_ISSUE;
          start   = 1'b1;
          // D wins a tie unless I has been passed over STARVE_MAX times in a row
          grant_d = d_req && !(i_req && STARVE_EN && (starve_q == STARVE_TOP));
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (lat_q == LCW'(1)) begin
          state_d = S_DONE;
          capture = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_sel   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      i_done    <= 1'b0;
      d_done    <= 1'b0;
      busy      <= 1'b0;
      lat_q     <= '0;
      starve_q  <= '0;
      acc_we_q  <= 1'b0;
    end else begin
      mem_en <= start;
      i_done <= capture && !mem_sel;
      d_done <= capture && mem_sel;
      busy   <= (state_d != S_IDLE);
      if (start) begin
        mem_sel   <= grant_d;
        mem_addr  <= grant_d ? d_addr : i_addr;
        mem_wdata <= grant_d ? d_wdata : '0;
        mem_we    <= grant_d && d_we;
        acc_we_q  <= grant_d && d_we;
        if (!grant_d)
          starve_q <= '0;
        else if (i_req && (starve_q != STARVE_TOP))
          starve_q <= starve_q + 1'b1;
      end else begin
        mem_we <= 1'b0;
      end
      if (state_q == S_ISSUE)
        lat_q <= LAT_LOAD;
      else if (state_q == S_WAIT)
        lat_q <= lat_q - 1'b1;
      // writes never touch d_rdata; the read data lands only in the owner's register
      if (capture) begin
        if (!mem_sel)
          i_rdata <= mem_rdata;
        else if (!acc_we_q)
          d_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: three instances with different latency/starvation
// settings, a memory model that drives valid data only in the response cycle, and a grant model.
module tb_mem_port_arbiter;

  localparam int NI = 3;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n   [NI];
  logic        i_req   [NI];
  logic        d_req   [NI];
  logic        d_we    [NI];
  logic [31:0] i_addr  [NI];
  logic [31:0] d_addr  [NI];
  logic [31:0] d_wdata [NI];
  logic [31:0] mem_rdata [NI];
  logic [31:0] i_rdata [NI];
  logic [31:0] d_rdata [NI];
  logic [31:0] mem_addr  [NI];
  logic [31:0] mem_wdata [NI];
  logic        i_done [NI];
  logic        d_done [NI];
  logic        mem_en [NI];
  logic        mem_we [NI];
  logic        mem_sel [NI];
  logic        busy [NI];

  mem_port_arbiter #(.XLEN(32), .MEM_LAT(1), .STARVE_MAX(4)) u0 (
    .clk(clk), .rst_n(rst_n[0]), .i_req(i_req[0]), .i_addr(i_addr[0]), .i_rdata(i_rdata[0]),
    .i_done(i_done[0]), .d_req(d_req[0]), .d_we(d_we[0]), .d_addr(d_addr[0]),
    .d_wdata(d_wdata[0]), .d_rdata(d_rdata[0]), .d_done(d_done[0]), .mem_en(mem_en[0]),
    .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
    .mem_rdata(mem_rdata[0]), .mem_sel(mem_sel[0]), .busy(busy[0]));

  mem_port_arbiter #(.XLEN(32), .MEM_LAT(4), .STARVE_MAX(0)) u1 (
    .clk(clk), .rst_n(rst_n[1]), .i_req(i_req[1]), .i_addr(i_addr[1]), .i_rdata(i_rdata[1]),
    .i_done(i_done[1]), .d_req(d_req[1]), .d_we(d_we[1]), .d_addr(d_addr[1]),
    .d_wdata(d_wdata[1]), .d_rdata(d_rdata[1]), .d_done(d_done[1]), .mem_en(mem_en[1]),
    .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
    .mem_rdata(mem_rdata[1]), .mem_sel(mem_sel[1]), .busy(busy[1]));

  mem_port_arbiter #(.XLEN(32), .MEM_LAT(3), .STARVE_MAX(4)) u2 (
    .clk(clk), .rst_n(rst_n[2]), .i_req(i_req[2]), .i_addr(i_addr[2]), .i_rdata(i_rdata[2]),
    .i_done(i_done[2]), .d_req(d_req[2]), .d_we(d_we[2]), .d_addr(d_addr[2]),
    .d_wdata(d_wdata[2]), .d_rdata(d_rdata[2]), .d_done(d_done[2]), .mem_en(mem_en[2]),
    .mem_we(mem_we[2]), .mem_addr(mem_addr[2]), .mem_wdata(mem_wdata[2]),
    .mem_rdata(mem_rdata[2]), .mem_sel(mem_sel[2]), .busy(busy[2]));

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : (k == 1) ? 4 : 3;
  endfunction

  function automatic int smax_of(input int k);
    return (k == 1) ? 0 : 4;
  endfunction

  function automatic logic [31:0] mdata(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'hDEAD_BEEF;
    return (a * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
  endfunction

  int total = 0;
  int bad   = 0;
  int tcyc  = 0;
  int sc [NI];

  // memory: response valid only in the MEM_LAT-th cycle after the command cycle
  int          cyc = 0;
  logic        pend [NI];
  int          mcnt [NI];
  logic [31:0] maddr [NI];
  int          we_viol = 0;
  always @(negedge clk) begin
    cyc++;
    for (int k = 0; k < NI; k++) begin
      if (rst_n[k] !== 1'b1) begin
        pend[k] = 1'b0;
        mcnt[k] = 0;
        mem_rdata[k] = 32'hBAD0_0000 + 32'(cyc);
      end else begin
        if (mem_we[k] && !mem_en[k]) we_viol++;
        if (mem_en[k]) begin
          pend[k] = 1'b1; mcnt[k] = 0; maddr[k] = mem_addr[k];
        end else if (pend[k]) begin
          mcnt[k]++;
        end
        if (pend[k] && mcnt[k] == lat_of(k)) begin
          mem_rdata[k] = mdata(maddr[k]);
          pend[k] = 1'b0;
        end else begin
          mem_rdata[k] = 32'hBAD0_0000 + 32'(cyc);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    tcyc++;
  endtask

  task automatic access(input int k, input bit d, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input string tag);
    int L = lat_of(k);
    int n;
    bit extra = 1'b0;
    logic [31:0] pi = i_rdata[k];
    logic [31:0] pd = d_rdata[k];
    if (d) begin
      d_req[k] = 1'b1; d_we[k] = we; d_addr[k] = addr; d_wdata[k] = wdata;
    end else begin
      i_req[k] = 1'b1; i_addr[k] = addr;
      sc[k] = 0;
    end
    tick();
    chk({tag, "_en"},    32'(mem_en[k]), 1);
    chk({tag, "_sel"},   32'(mem_sel[k]), 32'(d));
    chk({tag, "_addr"},  mem_addr[k], addr);
    chk({tag, "_we"},    32'(mem_we[k]), 32'(d && we));
    chk({tag, "_wdata"}, mem_wdata[k], d ? wdata : 32'h0);
    chk({tag, "_busy"},  32'(busy[k]), 1);
    n = 1;
    while (!(d ? d_done[k] : i_done[k]) && n < L + 10) begin
      tick();
      n++;
      if (mem_en[k] || (d ? i_done[k] : d_done[k])) extra = 1'b1;
    end
    chk({tag, "_lat"}, 32'(n), 32'(L + 2));
    chk({tag, "_extra"}, 32'(extra), 0);
    if (d) begin
      chk({tag, "_drd"}, d_rdata[k], we ? pd : mdata(addr));
      chk({tag, "_ird"}, i_rdata[k], pi);
      d_req[k] = 1'b0;
    end else begin
      chk({tag, "_ird"}, i_rdata[k], mdata(addr));
      chk({tag, "_drd"}, d_rdata[k], pd);
      i_req[k] = 1'b0;
    end
    tick();
    chk({tag, "_idle"}, 32'({busy[k], i_done[k], d_done[k], mem_we[k]}), 0);
  endtask

  task automatic contention(input int k, input int ng, input string tag);
    int L = lat_of(k);
    int c;
    int last_en = 0;
    bit ed;
    i_req[k] = 1'b1; i_addr[k] = $urandom & 32'hFFFF_FFFC;
    d_req[k] = 1'b1; d_we[k] = 1'b0; d_addr[k] = $urandom & 32'hFFFF_FFFC;
    d_wdata[k] = $urandom;
    for (int g = 0; g < ng; g++) begin
      c = 0;
      do begin tick(); c++; end while (!mem_en[k] && c < L + 8);
      ed = !(smax_of(k) != 0 && sc[k] == smax_of(k));
      if (!ed) sc[k] = 0;
      else if (sc[k] < smax_of(k)) sc[k]++;
      chk({tag, "_sel"},  32'(mem_sel[k]), 32'(ed));
      chk({tag, "_addr"}, mem_addr[k], ed ? d_addr[k] : i_addr[k]);
      if (g > 0) chk({tag, "_gap"}, 32'(tcyc - last_en), 32'(L + 3));
      last_en = tcyc;
      c = 0;
      do begin tick(); c++; end while (!(ed ? d_done[k] : i_done[k]) && c < L + 8);
      if (ed) begin
        chk({tag, "_drd"}, d_rdata[k], mdata(d_addr[k]));
        d_addr[k] = $urandom & 32'hFFFF_FFFC;
      end else begin
        chk({tag, "_ird"}, i_rdata[k], mdata(i_addr[k]));
        i_addr[k] = $urandom & 32'hFFFF_FFFC;
      end
    end
    i_req[k] = 1'b0; d_req[k] = 1'b0;
    tick();
    chk({tag, "_end"}, 32'(busy[k]), 0);
  endtask

  task automatic back_to_back(input int k, input int n, input string tag);
    int L = lat_of(k);
    int prev = tcyc;
    int c;
    i_req[k] = 1'b1; i_addr[k] = $urandom & 32'hFFFF_FFFC;
    for (int j = 0; j < n; j++) begin
      c = 0;
      do begin tick(); c++; end while (!i_done[k] && c < L + 10);
      chk({tag, "_period"}, 32'(tcyc - prev), (j == 0) ? 32'(L + 2) : 32'(L + 3));
      chk({tag, "_ird"}, i_rdata[k], mdata(i_addr[k]));
      prev = tcyc;
      sc[k] = 0;
      i_addr[k] = $urandom & 32'hFFFF_FFFC;
    end
    i_req[k] = 1'b0;
    tick();
  endtask

  task automatic rand_run(input int k, input int iters, input string tag);
    int L = lat_of(k);
    int n;
    bit ip = 1'b0, dp = 1'b0, own_d, cont;
    logic [31:0] pi, pd;
    for (int it = 0; it < iters; it++) begin
      if (!ip && $urandom_range(1) == 1) begin
        i_req[k] = 1'b1; i_addr[k] = $urandom & 32'hFFFF_FFFC; ip = 1'b1;
      end
      if (!dp && $urandom_range(1) == 1) begin
        d_req[k] = 1'b1; d_we[k] = 1'($urandom_range(1));
        d_addr[k] = $urandom & 32'hFFFF_FFFC; d_wdata[k] = $urandom; dp = 1'b1;
      end
      if (!ip && !dp) begin
        d_req[k] = 1'b1; d_we[k] = 1'b0; d_addr[k] = $urandom & 32'hFFFF_FFFC; dp = 1'b1;
      end
      cont  = ip && dp;
      own_d = dp && !(cont && smax_of(k) != 0 && sc[k] == smax_of(k));
      if (!own_d) sc[k] = 0;
      else if (cont && sc[k] < smax_of(k)) sc[k]++;
      pi = i_rdata[k]; pd = d_rdata[k];
      tick();
      chk({tag, "_en"},   32'(mem_en[k]), 1);
      chk({tag, "_sel"},  32'(mem_sel[k]), 32'(own_d));
      chk({tag, "_addr"}, mem_addr[k], own_d ? d_addr[k] : i_addr[k]);
      n = 1;
      while (!(own_d ? d_done[k] : i_done[k]) && n < L + 10) begin tick(); n++; end
      chk({tag, "_lat"}, 32'(n), 32'(L + 2));
      if (own_d) begin
        chk({tag, "_drd"}, d_rdata[k], d_we[k] ? pd : mdata(d_addr[k]));
        chk({tag, "_ird"}, i_rdata[k], pi);
        d_req[k] = 1'b0; dp = 1'b0;
      end else begin
        chk({tag, "_ird"}, i_rdata[k], mdata(i_addr[k]));
        chk({tag, "_drd"}, d_rdata[k], pd);
        i_req[k] = 1'b0; ip = 1'b0;
      end
      tick();
    end
    i_req[k] = 1'b0; d_req[k] = 1'b0;
    tick();
    chk({tag, "_end"}, 32'(busy[k]), 0);
  endtask

  task automatic reset_mid_wait(input int k);
    int L = lat_of(k);
    bit seen = 1'b0;
    d_req[k] = 1'b1; d_we[k] = 1'b0; d_addr[k] = 32'h0000_0080;
    tick();
    tick();
    tick();
    chk("rmw_busy_pre", 32'(busy[k]), 1);
    rst_n[k] = 1'b0;
    #1;
    chk("rmw_ctl", 32'({busy[k], mem_en[k], mem_we[k], mem_sel[k], i_done[k], d_done[k]}), 0);
    chk("rmw_data", i_rdata[k] | d_rdata[k] | mem_addr[k] | mem_wdata[k], 0);
    d_req[k] = 1'b0;
    sc[k] = 0;
    tick();
    tick();
    rst_n[k] = 1'b1;
    for (int j = 0; j < L + 5; j++) begin
      tick();
      if (i_done[k] || d_done[k] || mem_en[k]) seen = 1'b1;
    end
    chk("rmw_no_done", 32'(seen), 0);
    access(k, 1'b1, 1'b0, 32'h0000_0040, 32'h0, "rmw_d40");
  endtask

  initial begin
    for (int k = 0; k < NI; k++) begin
      rst_n[k] = 1'b0; i_req[k] = 1'b0; d_req[k] = 1'b0; d_we[k] = 1'b0;
      i_addr[k] = '0; d_addr[k] = '0; d_wdata[k] = '0; sc[k] = 0;
      pend[k] = 1'b0; mcnt[k] = 0; maddr[k] = '0; mem_rdata[k] = '0;
    end
    repeat (4) begin
      for (int k = 0; k < NI; k++) begin
        i_req[k] = 1'($urandom_range(1)); d_req[k] = 1'($urandom_range(1));
        d_we[k] = 1'($urandom_range(1)); i_addr[k] = $urandom; d_addr[k] = $urandom;
        d_wdata[k] = $urandom;
      end
      tick();
      for (int k = 0; k < NI; k++) begin
        chk("rst_ctl", 32'({busy[k], mem_en[k], mem_we[k], mem_sel[k], i_done[k], d_done[k]}), 0);
        chk("rst_data", i_rdata[k] | d_rdata[k] | mem_addr[k] | mem_wdata[k], 0);
      end
    end
    for (int k = 0; k < NI; k++) begin
      i_req[k] = 1'b0; d_req[k] = 1'b0; d_we[k] = 1'b0;
      rst_n[k] = 1'b1;
    end
    repeat (3) tick();
    for (int k = 0; k < NI; k++) chk("post_rst_idle", 32'({mem_en[k], busy[k]}), 0);

    access(0, 1'b0, 1'b0, 32'h0000_0100, 32'h0, "i_read");
    access(0, 1'b1, 1'b0, 32'h0000_0300, 32'h0, "d_read");
    access(0, 1'b1, 1'b1, 32'h0000_2000, 32'h1234_5678, "d_write");
    contention(0, 10, "cont_s4");
    contention(1, 6, "cont_s0");
    access(1, 1'b0, 1'b0, 32'h0000_0100, 32'h0, "lat4_i");
    back_to_back(1, 3, "b2b_lat4");
    reset_mid_wait(2);
    rand_run(0, 30, "rnd0");
    rand_run(2, 20, "rnd2");
    chk("we_without_en", 32'(we_viol), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

- Shares the single unified memory port between the instruction-fetch requester (I-port) and the load/store requester (D-port).
- Sequences each fixed-latency memory access, registers the response and returns it with a one-cycle done pulse.
- Drives `mem_sel`, the select line for the datapath's address/data muxes in front of memory.
- Data accesses win contention by default; a starvation counter guarantees instruction fetch progress.

## Interface

Parameters:
- `XLEN`, 32: address/data width.
- `MEM_LAT`, 1: memory read latency in cycles from the command cycle to valid `mem_rdata`. Must be ≥1.
- `STARVE_MAX`, 4: number of consecutive contended D grants before a forced I grant. 0 means strict D priority.

Ports:
- `clk`  in  1  the single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `i_req`  in  1  I-port request; held with `i_addr` stable until `i_done`.
- `i_addr`  in  XLEN  I-port address; reads only.
- `i_rdata`  out  XLEN  I-port read data; valid when `i_done`=1.
- `i_done`  out  1  one-cycle completion pulse for the I-port.
- `d_req`  in  1  D-port request; held with `d_we`, `d_addr`, `d_wdata` stable until `d_done`.
- `d_we`  in  1  1 = write, 0 = read.
- `d_addr`  in  XLEN  D-port address.
- `d_wdata`  in  XLEN  D-port write data.
- `d_rdata`  out  XLEN  D-port read data; valid when `d_done`=1 for reads.
- `d_done`  out  1  one-cycle completion pulse for the D-port.
- `mem_en`  out  1  memory command strobe, one cycle per access.
- `mem_we`  out  1  memory write enable; only ever high together with `mem_en`.
- `mem_addr`  out  XLEN  memory address.
- `mem_wdata`  out  XLEN  memory write data.
- `mem_rdata`  in  XLEN  memory read data.
- `mem_sel`  out  1  current owner: 0 = I, 1 = D.
- `busy`  out  1  1 whenever the state is not IDLE.

## Operation

- FSM states: IDLE, ISSUE, WAIT, DONE.
- Reset (asynchronous, immediate):
  - State goes to IDLE. Any in-flight access is aborted and no done pulse is produced for it.
  - All outputs are 0: `mem_sel`=0, `i_rdata`=`d_rdata`=0, `busy`=0.
  - Starvation counter = 0.
- IDLE → ISSUE on an edge where `i_req` or `d_req` is sampled high. Winner selection:
  - Only one request high: that requester wins.
  - Both high: D wins, unless `STARVE_MAX`≠0 and the counter equals `STARVE_MAX`; then I wins.
- At the IDLE→ISSUE edge, the winner is latched into `mem_sel`, and its address/wdata/we into `mem_addr`/`mem_wdata`/`mem_we`. For an I access, `mem_we`=0 and `mem_wdata`=0.
- ISSUE lasts 1 cycle with `mem_en`=1. Then go to WAIT and load the latency counter with `MEM_LAT`.
- WAIT lasts exactly `MEM_LAT` cycles.
  - On the edge ending the last WAIT cycle, `mem_rdata` is captured into the owner's rdata register, for reads only.
  - Write accesses leave `d_rdata` unchanged.
- DONE lasts 1 cycle: the owner's done = 1, then go to IDLE.
- `mem_sel`, `mem_addr` and `mem_wdata` are held from ISSUE until the next grant. `mem_we` clears on leaving ISSUE.
- Starvation counter:
  - Increments, saturating at `STARVE_MAX`, on every D grant made while `i_req` is also high.
  - Clears on every I grant.
  - Uncontended D grants leave it unchanged.
- Requests seen in ISSUE, WAIT or DONE are ignored. They are sampled again in IDLE.
- A requester must deassert its req in the cycle after its done unless it is issuing a new request.
- The non-owner's rdata and done are unaffected by an access.

## Timing

- Request sampled in IDLE at cycle 0:
  - ISSUE in cycle 1.
  - WAIT in cycles 2..`MEM_LAT`+1.
  - DONE in cycle `MEM_LAT`+2.
- Memory contract: `mem_rdata` is valid in cycle 1+`MEM_LAT`.
- Back-to-back requests from a continuously requesting port start every `MEM_LAT`+3 cycles, because there is one IDLE cycle between accesses.
- All outputs are registered. There is no combinational path from any input to any output.
- Simultaneous requests in the same IDLE cycle are resolved by the arbitration rule only. Arrival order is not considered.
- Reset asserted during WAIT: the memory response is discarded and no done pulse is produced. After reset release, the first request is served with normal latency.

## Test plan

- Reset: hold `rst_n`=0 with random inputs → every output is 0 and `busy`=0. Release → state is IDLE, with no `mem_en` until a request arrives.
- I read, `MEM_LAT`=1: `i_req`=1, `i_addr`=0x100, memory returns 0xDEADBEEF →
  - cycle 1: `mem_en`=1, `mem_addr`=0x100, `mem_sel`=0.
  - cycle 3: `i_done`=1, `i_rdata`=0xDEADBEEF.
  - `d_done` stays 0 throughout.
- D write: `d_req`=1, `d_we`=1, `d_addr`=0x2000, `d_wdata`=0x12345678 →
  - one cycle with `mem_en`=`mem_we`=1 and `mem_sel`=1.
  - `d_done` in cycle `MEM_LAT`+2.
  - `d_rdata` unchanged from its prior value.
- Contention, `STARVE_MAX`=4: both ports request continuously, re-requesting after each done → grant order D,D,D,D,I,D,D,D,D,I. Repeat with `STARVE_MAX`=0 → I is never granted while `d_req` is high.
- Latency, `MEM_LAT`=4: I read at cycle 0 → `i_done` at cycle 6 with the captured data. Back-to-back I requests complete every 7 cycles.
- Reset mid-WAIT, `MEM_LAT`=3: assert `rst_n`=0 in the second WAIT cycle →
  - outputs go to 0 immediately.
  - no done pulse after release.
  - the next D read to 0x40 completes normally in 5 cycles.
